imager_capture_ctrl: RTL and testbench
======================================

# imager_capture_ctrl

Capture sequencer for the `imager_rx` receive path, running in the `clki` domain:
- Drives the `enable` and `header_stall` inputs of `imager_rx`.
- Watches the `dvo`/`dtypeo` stream of `imager_rx` to track frame boundaries.
- Delivers single, burst or continuous captures made only of whole frames.
- Reports progress, completion and timeout/sequence errors to the register/status layer.

## Interface
- `COUNT_WIDTH`, 16, width of frame-count request and captured-frame counter
- `TIMEOUT_WIDTH`, 32, width of the per-frame timeout in `clki` cycles
- `clki` in 1: sole clock; all logic is on its rising edge
- `reset_clki` in 1: asynchronous, active-high reset
- `cmd_start` in 1: single-cycle start request
- `cmd_stop` in 1: single-cycle stop request
- `cmd_mode` in 2: 0 single, 1 burst, 2 continuous; 3 is treated as single
- `cmd_num_frames` in COUNT_WIDTH: burst length, sampled on an accepted start
- `frame_timeout` in TIMEOUT_WIDTH: max cycles in ARM or FRAME; 0 disables the timeout
- `pipe_ready` in 1: downstream can accept header words
- `rx_dvo` in 1: `dvo` output of `imager_rx`
- `rx_dtypeo` in `DTYPE_WIDTH`: `dtypeo` output of `imager_rx`
- `rx_enable` out 1: drives `imager_rx` `enable`
- `rx_header_stall` out 1: drives `imager_rx` `header_stall`
- `busy` out 1: state is not IDLE
- `done` out 1: one-cycle pulse when the capture completes normally
- `timeout_err` out 1: one-cycle pulse when the timeout aborts a capture
- `seq_err` out 1: one-cycle pulse on an out-of-order dtype
- `frames_captured` out COUNT_WIDTH: whole frames completed in the current capture
- `state` out 2: current FSM state, for status readback

## Operation
- **Frame events:** decoded only when `rx_dvo`=1.
  - SOF = `DTYPE_FRAME_START`
  - EOF = `DTYPE_FRAME_END`
  - HEND = `DTYPE_HEADER_END`
- **FSM states:** IDLE=0, ARM=1, FRAME=2, HEADER=3.
- **IDLE:**
  - `rx_enable`=0.
  - `cmd_start`, with `cmd_stop` low, moves to ARM.
  - On that transition: latch the target (single→1, burst→`cmd_num_frames` with 0 treated as 1, continuous→unbounded), clear `frames_captured`, clear `stop_pend`.
- **ARM:**
  - `rx_enable`=1.
  - SOF moves to FRAME.
  - `cmd_stop` moves directly to IDLE with no `done`; no frame has been emitted yet.
- **FRAME:**
  - EOF moves to HEADER.
  - SOF again: pulse `seq_err` and stay in FRAME (frame restart).
- **HEADER:**
  - SOF: pulse `seq_err` and move to FRAME.
  - HEND: `frames_captured`+1.
  - After HEND, if the target is reached or `stop_pend`=1: pulse `done`, deassert `rx_enable`, go to IDLE. Otherwise go to ARM.
- **`cmd_stop` in FRAME or HEADER:** sets `stop_pend`; the current frame and its header always finish.
- **`rx_header_stall`:** registered `!pipe_ready` while in FRAME or HEADER, otherwise 0.
- **Ignored commands:**
  - `cmd_start` while `busy`.
  - `cmd_start` together with `cmd_stop` in IDLE (no capture starts).
- **Counter width:** `frames_captured` wraps modulo 2^COUNT_WIDTH in continuous mode.

## Timing
- **Reset values:** all outputs 0, `state`=IDLE, `stop_pend`=0, timeout counter 0.
- **Start:** `cmd_start` at cycle n gives `rx_enable`=1 and `busy`=1 at n+1.
- **Frame end:** HEND at cycle n gives `frames_captured` updated at n+1.
  - On the final frame, `done`=1, `rx_enable`=0 and `busy`=0 also at n+1.
- **Header stall:** `rx_header_stall` follows `pipe_ready` with 1-cycle latency.
- **Event precedence in one cycle:** `dtypeo` event first, then `cmd_stop`, then timeout.
- **HEND with `cmd_stop` in the same cycle:** the completion is counted and the capture ends with `done`.
- **Reset mid-capture:** returns to IDLE immediately with `rx_enable`=0. `imager_rx` then waits for fv to drop on its own.

## Configuration
- **Macro:** `IMAGER_CAPTURE_TIMEOUT_EN`.
- **Defined:**
  - Counter clears on entry to ARM and on entry to FRAME, and counts each cycle in ARM or FRAME.
  - If `frame_timeout`≠0 and the count equals `frame_timeout`: pulse `timeout_err`, set `rx_enable`=0, go to IDLE without `done`.
  - HEADER is never timed.
- **Undefined:** no counter is built, `frame_timeout` is ignored, and `timeout_err` is tied to 0.

## Structure
- **Shared package `imager_capture_pkg`:**
  - State encoding (IDLE/ARM/FRAME/HEADER).
  - Mode constants (`CAP_SINGLE`, `CAP_BURST`, `CAP_CONT`).
  - Dtype codes come from the existing `dtypes.v`.
- **Sub-module `imager_capture_timeout`:** the clear/enable/compare counter. It is instantiated only under the macro.

## Test plan
- **Single capture:** `cmd_mode`=0, start, stream SOF→pixels→EOF→HEND → `done` pulse 1 cycle after HEND, `frames_captured`=1, `rx_enable` low.
- **Burst:** `cmd_mode`=1, `cmd_num_frames`=3, three frames → state cycles ARM/FRAME/HEADER ×3, `done` after the 3rd HEND, `frames_captured`=3. Repeat with `cmd_num_frames`=0 → ends after 1 frame.
- **Continuous with stop:** `cmd_mode`=2, stop during the 2nd frame's pixels → frame 2 completes, `done` at HEND+1, `frames_captured`=2. Stop while in ARM → IDLE next cycle, no `done`.
- **Header stall:** `pipe_ready`=0 from EOF for 5 cycles → `rx_header_stall`=1 from EOF+1 through 1 cycle after `pipe_ready` rises. Also check `rx_header_stall`=0 in IDLE/ARM.
- **Timeout:** macro on, `frame_timeout`=100, no SOF → `timeout_err` pulse 100 cycles after ARM entry, IDLE, `rx_enable`=0. Macro off, same stimulus → stays in ARM, `timeout_err`=0.
- **Sequence errors:** SOF, SOF, EOF, HEND → `seq_err` pulse on the 2nd SOF, frame still counted. Also: `cmd_start` while busy is ignored, and `cmd_start`+`cmd_stop` in IDLE stays in IDLE.

Source files
------------

// File: rtl/imager_capture_pkg.sv
// -----------------------------------------------------------------------------
// imager_capture_pkg
// Shared definitions for the imager capture sequencer: FSM state encoding,
// capture mode constants and the imager_rx dtype codes it decodes.
// No ports (package).
// -----------------------------------------------------------------------------
package imager_capture_pkg;

   // Dtype codes, kept identical to dtypes.v of imager_rx
   localparam int unsigned DTYPE_WIDTH = 4;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL       = 4'h0;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 4'h1;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 4'h2;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER      = 4'h3;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_END  = 4'h4;

   // Encoding is visible through the status readback, so it is fixed
   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StArm    = 2'd1,
      StFrame  = 2'd2,
      StHeader = 2'd3
   } cap_state_e;

   localparam logic [1:0] CAP_SINGLE = 2'd0;
   localparam logic [1:0] CAP_BURST  = 2'd1;
   localparam logic [1:0] CAP_CONT   = 2'd2;

endpackage

// File: rtl/imager_capture_ctrl_if.sv
// -----------------------------------------------------------------------------
// imager_capture_ctrl_if
// Bundles the command, status and imager_rx-facing signals of the capture
// sequencer.
//   master : drives commands, pipe_ready and the rx dvo/dtypeo stream;
//            receives rx_enable, rx_header_stall and status
//   slave  : the sequencer itself (imager_capture_ctrl)
// -----------------------------------------------------------------------------
interface imager_capture_ctrl_if
   import imager_capture_pkg::*;
#(
   parameter int unsigned COUNT_WIDTH   = 16,
   parameter int unsigned TIMEOUT_WIDTH = 32
);

   logic                     cmd_start;
   logic                     cmd_stop;
   logic [1:0]               cmd_mode;
   logic [COUNT_WIDTH-1:0]   cmd_num_frames;
   logic [TIMEOUT_WIDTH-1:0] frame_timeout;
   logic                     pipe_ready;
   logic                     rx_dvo;
   logic [DTYPE_WIDTH-1:0]   rx_dtypeo;
   logic                     rx_enable;
   logic                     rx_header_stall;
   logic                     busy;
   logic                     done;
   logic                     timeout_err;
   logic                     seq_err;
   logic [COUNT_WIDTH-1:0]   frames_captured;
   logic [1:0]               state;

   modport master (
      output cmd_start, cmd_stop, cmd_mode, cmd_num_frames, frame_timeout, pipe_ready,
             rx_dvo, rx_dtypeo,
      input  rx_enable, rx_header_stall, busy, done, timeout_err, seq_err, frames_captured,
             state
   );

   modport slave (
      input  cmd_start, cmd_stop, cmd_mode, cmd_num_frames, frame_timeout, pipe_ready,
             rx_dvo, rx_dtypeo,
      output rx_enable, rx_header_stall, busy, done, timeout_err, seq_err, frames_captured,
             state
   );

endinterface

// File: rtl/imager_capture_timeout.sv
// -----------------------------------------------------------------------------
// imager_capture_timeout
// Per-state cycle counter used by the capture sequencer to abort stuck
// captures. Only instantiated when IMAGER_CAPTURE_TIMEOUT_EN is defined.
//   clki, reset_clki : clock, async active-high reset
//   clear_i          : zero the counter (state entry); wins over count_en_i
//   count_en_i       : count this cycle
//   limit_i          : cycle limit, 0 disables expiry
//   expired_o        : this counted cycle is the limit_i-th one
// -----------------------------------------------------------------------------
module imager_capture_timeout #(
   parameter int unsigned TIMEOUT_WIDTH = 32
) (
   input  logic                     clki,
   input  logic                     reset_clki,
   input  logic                     clear_i,
   input  logic                     count_en_i,
   input  logic [TIMEOUT_WIDTH-1:0] limit_i,
   output logic                     expired_o
);

   logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;

   assign cnt_inc = cnt_q + TIMEOUT_WIDTH'(1);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (count_en_i) begin
         cnt_d = cnt_inc;
      end
   end

   // Compare against the post-increment value so that the state is left after
   // exactly limit_i cycles in it.
   assign expired_o = count_en_i && (limit_i != '0) && (cnt_inc == limit_i);

   always_ff @(posedge clki or posedge reset_clki) begin
      if (reset_clki) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/imager_capture_ctrl.sv
// -----------------------------------------------------------------------------
// imager_capture_ctrl
// Capture sequencer for the imager_rx receive path. Enables imager_rx, tracks
// frame boundaries on its dvo/dtypeo stream and delivers single, burst or
// continuous captures made only of whole frames.
//   clki, reset_clki : clock, async active-high reset
//   cap (slave)      : commands (start/stop/mode/num_frames/frame_timeout),
//                      pipe_ready, rx dvo/dtypeo in; rx_enable,
//                      rx_header_stall, busy, done, timeout_err, seq_err,
//                      frames_captured, state out
// Build option: IMAGER_CAPTURE_TIMEOUT_EN adds the ARM/FRAME timeout; without
// it frame_timeout is ignored and timeout_err stays 0.
// -----------------------------------------------------------------------------
module imager_capture_ctrl
   import imager_capture_pkg::*;
#(
   parameter int unsigned COUNT_WIDTH   = 16,
   parameter int unsigned TIMEOUT_WIDTH = 32
) (
   input logic                  clki,
   input logic                  reset_clki,
   imager_capture_ctrl_if.slave cap
);

   cap_state_e             state_q, state_d;
   logic [COUNT_WIDTH-1:0] target_q, target_d;
   logic [COUNT_WIDTH-1:0] frames_q, frames_d, frames_inc;
   logic                   cont_q, cont_d;
   logic                   stop_pend_q, stop_pend_d;
   logic                   hstall_q, hstall_d;
   logic                   done_q, done_d;
   logic                   tout_q, tout_d;
   logic                   seq_q, seq_d;

   logic ev_sof, ev_eof, ev_hend;
   logic start_ok, hend_last;
   logic tmo_clear, tmo_en, tmo_expired;
   logic rx_enable, busy;

   assign ev_sof  = cap.rx_dvo && (cap.rx_dtypeo == DTYPE_FRAME_START);
   assign ev_eof  = cap.rx_dvo && (cap.rx_dtypeo == DTYPE_FRAME_END);
   assign ev_hend = cap.rx_dvo && (cap.rx_dtypeo == DTYPE_HEADER_END);

   assign start_ok   = cap.cmd_start && !cap.cmd_stop;
   assign frames_inc = frames_q + COUNT_WIDTH'(1);

   // A same-cycle stop still lets this header complete and ends the capture
   assign hend_last = ev_hend &&
                      ((!cont_q && (frames_inc == target_q)) || stop_pend_q || cap.cmd_stop);

   assign tmo_en = (state_q == StArm) || (state_q == StFrame);

`ifdef IMAGER_CAPTURE_TIMEOUT_EN
   imager_capture_timeout #(
      .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
   ) u_timeout (
      .clki      (clki),
      .reset_clki(reset_clki),
      .clear_i   (tmo_clear),
      .count_en_i(tmo_en),
      .limit_i   (cap.frame_timeout),
      .expired_o (tmo_expired)
   );
`else
   logic unused_timeout;
   assign unused_timeout = ^{cap.frame_timeout, tmo_clear, tmo_en};
   assign tmo_expired    = 1'b0;
`endif

   // State register
   always_ff @(posedge clki or posedge reset_clki) begin
      if (reset_clki) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; dtype events take precedence over stop, stop over timeout
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start_ok) state_d = StArm;
         end
         StArm: begin
            if (ev_sof) begin
               state_d = StFrame;
            end else if (cap.cmd_stop || tmo_expired) begin
               state_d = StIdle;
            end
         end
         StFrame: begin
            if (ev_eof) begin
               state_d = StHeader;
            end else if (!ev_sof && tmo_expired) begin
               state_d = StIdle;
            end
         end
         StHeader: begin
            if (ev_sof) begin
               state_d = StFrame;
            end else if (ev_hend) begin
               state_d = hend_last ? StIdle : StArm;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath next values and registered status pulses
   always_comb begin
      target_d    = target_q;
      cont_d      = cont_q;
      frames_d    = frames_q;
      stop_pend_d = stop_pend_q;

      done_d   = (state_q == StHeader) && hend_last;
      seq_d    = ev_sof && ((state_q == StFrame) || (state_q == StHeader));
      tout_d   = tmo_expired &&
                 (((state_q == StArm) && !ev_sof && !cap.cmd_stop) ||
                  ((state_q == StFrame) && !ev_sof && !ev_eof));
      hstall_d = ((state_q == StFrame) || (state_q == StHeader)) && !cap.pipe_ready;

      // A frame restart counts as a fresh entry into FRAME
      tmo_clear = ((state_d != state_q) && ((state_d == StArm) || (state_d == StFrame))) ||
                  ((state_q == StFrame) && ev_sof);

      if ((state_q == StIdle) && start_ok) begin
         frames_d    = '0;
         stop_pend_d = 1'b0;
         case (cap.cmd_mode)
            CAP_BURST: begin
               cont_d   = 1'b0;
               target_d = (cap.cmd_num_frames == '0) ? COUNT_WIDTH'(1) : cap.cmd_num_frames;
            end
            CAP_CONT: begin
               cont_d   = 1'b1;
               target_d = COUNT_WIDTH'(1);
            end
            default: begin
               cont_d   = 1'b0;
               target_d = COUNT_WIDTH'(1);
            end
         endcase
      end

      if ((state_q == StHeader) && ev_hend) frames_d = frames_inc;

      // Stop never cuts a frame short; it is remembered until the header ends
      if (cap.cmd_stop && ((state_d == StFrame) || (state_d == StHeader))) stop_pend_d = 1'b1;
   end

   always_ff @(posedge clki or posedge reset_clki) begin
      if (reset_clki) begin
         target_q    <= '0;
         cont_q      <= 1'b0;
         frames_q    <= '0;
         stop_pend_q <= 1'b0;
         hstall_q    <= 1'b0;
         done_q      <= 1'b0;
         tout_q      <= 1'b0;
         seq_q       <= 1'b0;
      end else begin
         target_q    <= target_d;
         cont_q      <= cont_d;
         frames_q    <= frames_d;
         stop_pend_q <= stop_pend_d;
         hstall_q    <= hstall_d;
         done_q      <= done_d;
         tout_q      <= tout_d;
         seq_q       <= seq_d;
      end
   end

   // Outputs decoded from state
   always_comb begin
      rx_enable = (state_q != StIdle);
      busy      = (state_q != StIdle);
   end

   assign cap.rx_enable       = rx_enable;
   assign cap.busy            = busy;
   assign cap.rx_header_stall = hstall_q;
   assign cap.done            = done_q;
   assign cap.timeout_err     = tout_q;
   assign cap.seq_err         = seq_q;
   assign cap.frames_captured = frames_q;
   assign cap.state           = state_q;

endmodule

// File: tb/tb_imager_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imager_capture_ctrl
// Self-checking bench for imager_capture_ctrl: a per-cycle vector table for a
// single capture (ignored commands, frame restart, header stall), then
// directed sequences for burst, continuous/stop, reset and timeout cases.
// -----------------------------------------------------------------------------
module tb_imager_capture_ctrl;
   import imager_capture_pkg::*;

   localparam int unsigned CW = 16;
   localparam int unsigned TW = 32;
   localparam int unsigned NV = 13;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   imager_capture_ctrl_if #(.COUNT_WIDTH(CW), .TIMEOUT_WIDTH(TW)) cif ();

   imager_capture_ctrl #(
      .COUNT_WIDTH  (CW),
      .TIMEOUT_WIDTH(TW)
   ) dut (
      .clki      (clk),
      .reset_clki(rst),
      .cap       (cif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic          start;
      logic          stop;
      logic [1:0]    mode;
      logic [CW-1:0] nf;
      logic          pr;
      logic          dvo;
      logic [3:0]    dt;
      cap_state_e    e_state;
      logic          e_en;
      logic          e_done;
      logic          e_seq;
      logic          e_stall;
      logic [CW-1:0] e_frames;
   } vec_t;

   vec_t vec [NV];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [3:0] dt);
      cif.rx_dvo    = 1'b1;
      cif.rx_dtypeo = dt;
      tick();
      cif.rx_dvo    = 1'b0;
      cif.rx_dtypeo = DTYPE_PIXEL;
   endtask

   task automatic start(input logic [1:0] mode, input logic [CW-1:0] nf);
      cif.cmd_mode       = mode;
      cif.cmd_num_frames = nf;
      cif.cmd_start      = 1'b1;
      tick();
      cif.cmd_start      = 1'b0;
   endtask

   task automatic chk_status(input string tag, input cap_state_e st, input logic dn,
                             input logic [CW-1:0] frames);
      chk({tag, ".state"}, 32'(cif.state), 32'(st));
      chk({tag, ".rx_enable"}, 32'(cif.rx_enable), 32'(st != StIdle));
      chk({tag, ".busy"}, 32'(cif.busy), 32'(st != StIdle));
      chk({tag, ".done"}, 32'(cif.done), 32'(dn));
      chk({tag, ".frames"}, 32'(cif.frames_captured), 32'(frames));
   endtask

   task automatic run_frame(input string tag, input logic [CW-1:0] exp_frames, input logic last);
      send(DTYPE_FRAME_START);
      chk({tag, ".sof"}, 32'(cif.state), 32'(StFrame));
      send(DTYPE_PIXEL);
      send(DTYPE_PIXEL);
      send(DTYPE_FRAME_END);
      chk({tag, ".eof"}, 32'(cif.state), 32'(StHeader));
      send(DTYPE_HEADER);
      send(DTYPE_HEADER_END);
      chk_status({tag, ".hend"}, last ? StIdle : StArm, last, exp_frames);
   endtask

   initial begin
      checks             = 0;
      errors             = 0;
      rst                = 1'b1;
      cif.cmd_start      = 1'b0;
      cif.cmd_stop       = 1'b0;
      cif.cmd_mode       = CAP_SINGLE;
      cif.cmd_num_frames = '0;
      cif.frame_timeout  = '0;
      cif.pipe_ready     = 1'b1;
      cif.rx_dvo         = 1'b0;
      cif.rx_dtypeo      = DTYPE_PIXEL;

      //         start stop mode        nf      pr    dvo   dt                 state     en    done  seq   stall frames
      vec[0]  = '{1'b1, 1'b1, CAP_SINGLE, 16'd0, 1'b0, 1'b0, DTYPE_PIXEL,       StIdle,   1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
      vec[1]  = '{1'b1, 1'b0, CAP_SINGLE, 16'd0, 1'b1, 1'b0, DTYPE_PIXEL,       StArm,    1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
      vec[2]  = '{1'b0, 1'b0, CAP_SINGLE, 16'd0, 1'b0, 1'b0, DTYPE_PIXEL,       StArm,    1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
      vec[3]  = '{1'b1, 1'b0, CAP_BURST,  16'd5, 1'b1, 1'b0, DTYPE_PIXEL,       StArm,    1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
      vec[4]  = '{1'b0, 1'b0, CAP_SINGLE, 16'd0, 1'b1, 1'b1, DTYPE_FRAME_START, StFrame,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
      vec[5]  = '{1'b0, 1'b0, CAP_SINGLE, 16'd0, 1'b1, 1'b1, DTYPE_PIXEL,       StFrame,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
      vec[6]  = '{1'b0, 1'b0, CAP_SINGLE, 16'd0, 1'b1, 1'b1, DTYPE_FRAME_START, StFrame,  1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
      vec[7]  = '{1'b0, 1'b0, CAP_SINGLE, 16'd0, 1'b1, 1'b1, DTYPE_PIXEL,       StFrame,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
      vec[8]  = '{1'b0, 1'b0, CAP_SINGLE, 16'd0, 1'b0, 1'b1, DTYPE_FRAME_END,   StHeader, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0};
      vec[9]  = '{1'b0, 1'b0, CAP_SINGLE, 16'd0, 1'b0, 1'b1, DTYPE_HEADER,      StHeader, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0};
      vec[10] = '{1'b0, 1'b0, CAP_SINGLE, 16'd0, 1'b1, 1'b0, DTYPE_PIXEL,       StHeader, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
      vec[11] = '{1'b0, 1'b0, CAP_SINGLE, 16'd0, 1'b1, 1'b1, DTYPE_HEADER_END,  StIdle,   1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
      vec[12] = '{1'b0, 1'b0, CAP_SINGLE, 16'd0, 1'b1, 1'b0, DTYPE_PIXEL,       StIdle,   1'b0, 1'b0, 1'b0, 1'b0, 16'd1};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk_status("rst", StIdle, 1'b0, 16'd0);
      chk("rst.timeout_err", 32'(cif.timeout_err), 32'd0);
      chk("rst.seq_err", 32'(cif.seq_err), 32'd0);
      chk("rst.stall", 32'(cif.rx_header_stall), 32'd0);
      rst = 1'b0;
      tick();

      // Single capture, cycle by cycle
      for (int i = 0; i < NV; i++) begin
         cif.cmd_start      = vec[i].start;
         cif.cmd_stop       = vec[i].stop;
         cif.cmd_mode       = vec[i].mode;
         cif.cmd_num_frames = vec[i].nf;
         cif.pipe_ready     = vec[i].pr;
         cif.rx_dvo         = vec[i].dvo;
         cif.rx_dtypeo      = vec[i].dt;
         tick();
         chk($sformatf("v%0d.state", i), 32'(cif.state), 32'(vec[i].e_state));
         chk($sformatf("v%0d.rx_enable", i), 32'(cif.rx_enable), 32'(vec[i].e_en));
         chk($sformatf("v%0d.busy", i), 32'(cif.busy), 32'(vec[i].e_en));
         chk($sformatf("v%0d.done", i), 32'(cif.done), 32'(vec[i].e_done));
         chk($sformatf("v%0d.seq_err", i), 32'(cif.seq_err), 32'(vec[i].e_seq));
         chk($sformatf("v%0d.stall", i), 32'(cif.rx_header_stall), 32'(vec[i].e_stall));
         chk($sformatf("v%0d.frames", i), 32'(cif.frames_captured), 32'(vec[i].e_frames));
      end
      cif.cmd_start  = 1'b0;
      cif.cmd_stop   = 1'b0;
      cif.pipe_ready = 1'b1;
      cif.rx_dvo     = 1'b0;

      // Burst of three
      start(CAP_BURST, 16'd3);
      chk_status("burst3.start", StArm, 1'b0, 16'd0);
      for (int f = 1; f <= 3; f++) begin
         run_frame($sformatf("burst3.f%0d", f), CW'(f), f == 3);
      end
      tick();
      chk("burst3.done_pulse", 32'(cif.done), 32'd0);

      // Burst length 0 behaves as 1
      start(CAP_BURST, 16'd0);
      chk_status("burst0.start", StArm, 1'b0, 16'd0);
      run_frame("burst0", 16'd1, 1'b1);

      // Continuous, stop during second frame's pixels
      start(CAP_CONT, 16'd0);
      run_frame("cont.f1", 16'd1, 1'b0);
      send(DTYPE_FRAME_START);
      cif.cmd_stop = 1'b1;
      send(DTYPE_PIXEL);
      cif.cmd_stop = 1'b0;
      chk_status("cont.stop", StFrame, 1'b0, 16'd1);
      send(DTYPE_PIXEL);
      send(DTYPE_FRAME_END);
      send(DTYPE_HEADER_END);
      chk_status("cont.end", StIdle, 1'b1, 16'd2);

      // Stop while armed: no done
      start(CAP_CONT, 16'd0);
      tick();
      cif.cmd_stop = 1'b1;
      tick();
      cif.cmd_stop = 1'b0;
      chk_status("armstop", StIdle, 1'b0, 16'd0);

      // HEND and stop in the same cycle
      start(CAP_CONT, 16'd0);
      send(DTYPE_FRAME_START);
      send(DTYPE_FRAME_END);
      cif.cmd_stop = 1'b1;
      send(DTYPE_HEADER_END);
      cif.cmd_stop = 1'b0;
      chk_status("hendstop", StIdle, 1'b1, 16'd1);

      // Header stall: pipe_ready low for 5 cycles starting at EOF
      start(CAP_SINGLE, 16'd0);
      send(DTYPE_FRAME_START);
      send(DTYPE_PIXEL);
      cif.pipe_ready = 1'b0;
      send(DTYPE_FRAME_END);
      chk("stall.eof1", 32'(cif.rx_header_stall), 32'd1);
      for (int k = 2; k <= 5; k++) begin
         tick();
         chk($sformatf("stall.eof%0d", k), 32'(cif.rx_header_stall), 32'd1);
      end
      cif.pipe_ready = 1'b1;
      tick();
      chk("stall.release", 32'(cif.rx_header_stall), 32'd0);
      send(DTYPE_HEADER_END);
      chk_status("stall.end", StIdle, 1'b1, 16'd1);

      // Reset in the middle of a frame
      start(CAP_CONT, 16'd0);
      send(DTYPE_FRAME_START);
      chk("rstmid.pre", 32'(cif.state), 32'(StFrame));
      #2;
      rst = 1'b1;
      #1;
      chk_status("rstmid", StIdle, 1'b0, 16'd0);
      tick();
      rst = 1'b0;
      tick();

      // Timeout with no SOF
      cif.frame_timeout = 32'd100;
      start(CAP_SINGLE, 16'd0);
      chk("tmo.arm", 32'(cif.state), 32'(StArm));
      repeat (99) tick();
`ifdef IMAGER_CAPTURE_TIMEOUT_EN
      chk_status("tmo.pre", StArm, 1'b0, 16'd0);
      chk("tmo.pre.err", 32'(cif.timeout_err), 32'd0);
      tick();
      chk_status("tmo.hit", StIdle, 1'b0, 16'd0);
      chk("tmo.hit.err", 32'(cif.timeout_err), 32'd1);
      tick();
      chk("tmo.pulse", 32'(cif.timeout_err), 32'd0);
`else
      tick();
      chk_status("tmo.off", StArm, 1'b0, 16'd0);
      chk("tmo.off.err", 32'(cif.timeout_err), 32'd0);
      cif.cmd_stop = 1'b1;
      tick();
      cif.cmd_stop = 1'b0;
      chk("tmo.off.stop", 32'(cif.state), 32'(StIdle));
`endif
      cif.frame_timeout = '0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
